// File: rtl/dot_table_pkg.sv
// Shared widths, FSM state type and dot entry layout for the food-dot table.
// DOT_TABLE_HITBOX_EN adds the +/-1 proximity helper used by the hitbox match.
package dot_pkg;

    localparam int X_W    = 8;
    localparam int Y_W    = 7;
    localparam int C_W    = 3;
    localparam int DEPTH  = 128;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam int CNT_W  = 8;

    localparam logic [C_W-1:0] COLOUR_BLACK = '0;

    typedef enum logic [1:0] {
        S_LOAD,
        S_IDLE,
        S_SCAN,
        S_ERASE
    } state_t;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [C_W-1:0] colour;
    } dot_entry_t;

`ifdef DOT_TABLE_HITBOX_EN
    // Unsigned distance test; no wrap, so 0 and the maximum value are far apart.
    function automatic logic within_one(input logic [X_W-1:0] a, input logic [X_W-1:0] b);
        return ((a >= b) ? (a - b) : (b - a)) <= X_W'(1);
    endfunction
`endif

endpackage

// File: rtl/dot_table_if.sv
// Plotter, head-query and erase signals of the dot table grouped as one bus.
interface dot_table_if;
    import dot_pkg::*;

    logic             dot_plot_en;
    logic [X_W-1:0]   plot_x;
    logic [Y_W-1:0]   plot_y;
    logic [C_W-1:0]   plot_colour;
    logic             dots_done;
    logic             head_valid;
    logic [X_W-1:0]   head_x;
    logic [Y_W-1:0]   head_y;
    logic             head_ready;
    logic             query_done;
    logic             hit;
    logic [C_W-1:0]   hit_colour;
    logic             erase_en;
    logic [X_W-1:0]   erase_x;
    logic [Y_W-1:0]   erase_y;
    logic             erase_ack;
    logic [CNT_W-1:0] dot_count;
    logic             all_eaten;
    logic             overflow;

    modport master (
        output dot_plot_en, plot_x, plot_y, plot_colour, dots_done,
        output head_valid, head_x, head_y, erase_ack,
        input  head_ready, query_done, hit, hit_colour,
        input  erase_en, erase_x, erase_y, dot_count, all_eaten, overflow
    );

    modport slave (
        input  dot_plot_en, plot_x, plot_y, plot_colour, dots_done,
        input  head_valid, head_x, head_y, erase_ack,
        output head_ready, query_done, hit, hit_colour,
        output erase_en, erase_x, erase_y, dot_count, all_eaten, overflow
    );
endinterface

// File: rtl/dot_table_mem.sv
// Dot storage: synchronous write, combinational read at the scan index,
// and a valid-bit vector with a single-bit clear port for eaten dots.
module dot_mem
    import dot_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  dot_entry_t        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output dot_entry_t        rd_data,
    output logic              rd_valid,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr
);
    dot_entry_t       mem_q [DEPTH];
    logic [DEPTH-1:0] valid_q;

    // Contents need no reset: the valid bits alone decide what is live.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= '0;
        end else begin
            if (wr_en) begin
                valid_q[wr_addr] <= 1'b1;
            end
            if (clr_en) begin
                valid_q[clr_addr] <= 1'b0;
            end
        end
    end

    assign rd_data  = mem_q[rd_addr];
    assign rd_valid = valid_q[rd_addr];
endmodule

// File: rtl/dot_table.sv
// Food-dot table: captures plotted dots, then resolves head queries by linear scan.
// DOT_TABLE_HITBOX_EN widens the match from exact equality to a 3x3 hitbox.
module dot_table
    import dot_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    dot_table_if.slave bus
);
    state_t            state_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [ADDR_W-1:0] idx_q;
    logic [X_W-1:0]    head_x_q;
    logic [Y_W-1:0]    head_y_q;
    logic [CNT_W-1:0]  count_q;
    logic              dots_seen_q;
    logic              overflow_q;
    logic              head_ready_q;
    logic              query_done_q;
    logic              hit_q;
    logic [C_W-1:0]    hit_colour_q;
    logic              erase_en_q;
    logic [X_W-1:0]    erase_x_q;
    logic [Y_W-1:0]    erase_y_q;

    dot_entry_t wr_entry;
    dot_entry_t rd_entry;
    logic       rd_valid;
    logic       load_wr;
    logic       table_full;
    logic       mem_wr;
    logic       coord_match;
    logic       match;
    logic       scan_last;

    assign wr_entry   = '{x: bus.plot_x, y: bus.plot_y, colour: bus.plot_colour};
    assign load_wr    = (state_q == S_LOAD) && bus.dot_plot_en && (bus.plot_colour != COLOUR_BLACK);
    assign table_full = (wr_ptr_q == PTR_W'(DEPTH));
    assign mem_wr     = load_wr && !table_full;

`ifdef DOT_TABLE_HITBOX_EN
    assign coord_match = within_one(rd_entry.x, head_x_q) &&
                         within_one(X_W'(rd_entry.y), X_W'(head_y_q));
`else
    assign coord_match = (rd_entry.x == head_x_q) && (rd_entry.y == head_y_q);
`endif

    // An empty table must never report a hit from stale storage.
    assign match     = (state_q == S_SCAN) && (wr_ptr_q != '0) && rd_valid && coord_match;
    assign scan_last = (wr_ptr_q == '0) || (PTR_W'(idx_q) == wr_ptr_q - PTR_W'(1));

    dot_mem u_mem (
        .clk      (clk),
        .resetn   (resetn),
        .wr_en    (mem_wr),
        .wr_addr  (wr_ptr_q[ADDR_W-1:0]),
        .wr_data  (wr_entry),
        .rd_addr  (idx_q),
        .rd_data  (rd_entry),
        .rd_valid (rd_valid),
        .clr_en   (match),
        .clr_addr (idx_q)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_LOAD;
            wr_ptr_q     <= '0;
            idx_q        <= '0;
            head_x_q     <= '0;
            head_y_q     <= '0;
            count_q      <= '0;
            dots_seen_q  <= 1'b0;
            overflow_q   <= 1'b0;
            head_ready_q <= 1'b0;
            query_done_q <= 1'b0;
            hit_q        <= 1'b0;
            hit_colour_q <= '0;
            erase_en_q   <= 1'b0;
            erase_x_q    <= '0;
            erase_y_q    <= '0;
        end else begin
            query_done_q <= 1'b0;
            case (state_q)
                S_LOAD: begin
                    if (mem_wr) begin
                        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                        count_q  <= count_q + CNT_W'(1);
                    end
                    if (load_wr && table_full) begin
                        overflow_q <= 1'b1;
                    end
                    if (bus.dots_done) begin
                        dots_seen_q  <= 1'b1;
                        head_ready_q <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (bus.head_valid && head_ready_q) begin
                        head_x_q     <= bus.head_x;
                        head_y_q     <= bus.head_y;
                        idx_q        <= '0;
                        head_ready_q <= 1'b0;
                        state_q      <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (match) begin
                        count_q      <= count_q - CNT_W'(1);
                        query_done_q <= 1'b1;
                        hit_q        <= 1'b1;
                        hit_colour_q <= rd_entry.colour;
                        erase_x_q    <= rd_entry.x;
                        erase_y_q    <= rd_entry.y;
                        erase_en_q   <= 1'b1;
                        state_q      <= S_ERASE;
                    end else if (scan_last) begin
                        query_done_q <= 1'b1;
                        hit_q        <= 1'b0;
                        hit_colour_q <= '0;
                        head_ready_q <= 1'b1;
                        state_q      <= S_IDLE;
                    end else begin
                        idx_q <= idx_q + ADDR_W'(1);
                    end
                end
                S_ERASE: begin
                    if (bus.erase_ack) begin
                        erase_en_q   <= 1'b0;
                        head_ready_q <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_LOAD;
            endcase
        end
    end

    assign bus.head_ready = head_ready_q;
    assign bus.query_done = query_done_q;
    assign bus.hit        = hit_q;
    assign bus.hit_colour = hit_colour_q;
    assign bus.erase_en   = erase_en_q;
    assign bus.erase_x    = erase_x_q;
    assign bus.erase_y    = erase_y_q;
    assign bus.dot_count  = count_q;
    assign bus.all_eaten  = dots_seen_q && (count_q == '0);
    assign bus.overflow   = overflow_q;
endmodule

// File: doc/dot_table.md
# dot_table

Food-dot store sitting directly downstream of the random dot plotter. It captures every non-black dot the plotter emits while populating the screen, then serves snake-head position queries. On a hit it invalidates the dot, reports its colour for scoring, and issues a black-pixel erase request toward the VGA write path.

## Interface
- DEPTH, 128: maximum stored dots.
- X_W, 8: x coordinate width.
- Y_W, 7: y coordinate width.
- C_W, 3: colour width.

- clk  in  1  system clock (CLOCK_50).
- resetn  in  1  asynchronous, active-low reset.
- dot_plot_en  in  1  plotter write strobe.
- plot_x  in  X_W  plotter x.
- plot_y  in  Y_W  plotter y.
- plot_colour  in  C_W  plotter colour.
- dots_done  in  1  plotter finished; level, sticky until plotter reset.
- head_valid  in  1  head query request.
- head_x  in  X_W  query x.
- head_y  in  Y_W  query y.
- head_ready  out  1  table can accept a query.
- query_done  out  1  one-cycle pulse, query resolved.
- hit  out  1  qualifies query_done; 1 means dot eaten.
- hit_colour  out  C_W  colour of eaten dot, valid with query_done&&hit.
- erase_en  out  1  erase request to VGA path.
- erase_x  out  X_W  erase x.
- erase_y  out  Y_W  erase y.
- erase_ack  in  1  VGA path accepted erase.
- dot_count  out  8  live (valid) dots.
- all_eaten  out  1  dots_done seen and dot_count==0.
- overflow  out  1  sticky, a write was dropped because table full.

## Operation
- States: LOAD, IDLE, SCAN, ERASE. Reset state LOAD.
- LOAD: each cycle with dot_plot_en=1 and plot_colour!=0, write {x,y,colour} at wr_ptr, set valid, wr_ptr++, dot_count++. Colour 0 writes (screen clear) ignored. When wr_ptr==DEPTH, further writes dropped, overflow set. dots_done=1 -> IDLE; a write in that same cycle is still stored. dots_done ignored outside LOAD.
- IDLE: head_ready=1. head_valid&&head_ready captures head_x/head_y, idx=0 -> SCAN. If wr_ptr==0, SCAN finishes on its first cycle as a miss.
- SCAN: head_ready=0. One entry per cycle at idx. Match = valid[idx] && coordinate compare. On first match: clear valid[idx], dot_count--, pulse query_done with hit=1 and hit_colour, load erase_x/erase_y, -> ERASE. On idx==wr_ptr-1 with no match: pulse query_done with hit=0, -> IDLE. Entries beyond wr_ptr are never examined.
- ERASE: erase_en=1, coordinates held stable until the cycle erase_ack=1. On that edge erase_en drops and the state returns to IDLE. erase_ack outside ERASE is ignored.
- all_eaten is combinational from a registered dots-seen flag and dot_count.
- Reset outputs: head_ready 0, query_done 0, hit 0, hit_colour 0, erase_en 0, erase_x 0, erase_y 0, dot_count 0, all_eaten 0, overflow 0. All valid bits are cleared and wr_ptr is 0.

## Timing
- Query accepted at edge T. Entry k compared in cycle T+1+k. Hit at k gives query_done in cycle T+2+k and erase_en from cycle T+2+k.
- Miss with N stored entries gives query_done in cycle T+1+N. N=0 gives query_done in cycle T+2.
- After a miss, head_ready is 1 the cycle after query_done.
- After a hit, head_ready is 1 the cycle after the erase_ack edge.
- Only the lowest-index matching entry is consumed per query. Duplicate coordinates need repeated queries.
- Asynchronous reset in any state aborts immediately; erase_en drops with no ack required.

## Configuration
- DOT_TABLE_HITBOX_EN defined: match when |head_x-x|<=1 and |head_y-y|<=1, using unsigned compare without wrap (0 and 255 are not adjacent).
- Not defined: exact x and y equality only.

## Structure
- Package dot_pkg: X_W, Y_W, C_W, DEPTH, COLOUR_BLACK=0, state enum, dot entry struct {x,y,colour}.
- Sub-module dot_mem: DEPTH-entry storage plus valid-bit vector. Synchronous write, combinational read at idx, single-bit valid clear port.
- Match logic and FSM are in dot_table.

## Test plan
- Load: stream 5 writes, 2 with colour 0, then dots_done -> dot_count=3, head_ready=1 the next cycle, overflow=0.
- Hit: dots at (10,20,c=5),(30,40,c=2); query (30,40) -> query_done+hit at T+3, hit_colour=2; erase_en holds (30,40) through 4 cycles without ack, then drops on ack; dot_count=1.
- Miss and re-query: query (30,40) again -> query_done hit=0 at T+3; query (10,20) -> hit; all_eaten=1.
- Overflow: 130 non-black writes -> dot_count=128, overflow=1; miss query -> query_done at T+129.
- Empty table: dots_done with zero writes, query -> miss at T+2. Reset asserted during ERASE -> erase_en=0, state LOAD, dot_count=0 immediately.
- With DOT_TABLE_HITBOX_EN: dot (50,60), query (51,59) -> hit. Query (52,60) -> miss. Without the macro, query (51,59) -> miss.
